// File: rtl/blur_sequencer.sv
// Raster-order sequencer: walks one image pixel by pixel, asks the convolution
// engine for each blurred pixel and writes the result to the output image SRAM.
module blur_sequencer #(
    parameter int X_MAX       = 16,
    parameter int Y_MAX       = 16,
    parameter int PIXEL_DEPTH = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [2:0]               sigma_in,
    input  logic [$clog2(X_MAX):0]   img_w,
    input  logic [$clog2(Y_MAX):0]   img_h,
    output logic                     new_trans,
    output logic [2:0]               sigma,
    output logic                     start_conv,
    output logic [$clog2(X_MAX):0]   conv_x,
    output logic [$clog2(Y_MAX):0]   conv_y,
    input  logic                     conv_done,
    input  logic [PIXEL_DEPTH-1:0]   blurred_pixel,
    input  logic                     conv_err,
    output logic [$clog2(X_MAX):0]   out_x,
    output logic [$clog2(Y_MAX):0]   out_y,
    output logic [PIXEL_DEPTH-1:0]   out_wdat,
    output logic                     out_wen,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int XW = $clog2(X_MAX) + 1;
    localparam int YW = $clog2(Y_MAX) + 1;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [XW-1:0] X_LIM  = XW'(X_MAX);
    localparam logic [YW-1:0] Y_LIM  = YW'(Y_MAX);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        ISSUE,
        WAIT,
        WRITE,
        ADVANCE,
        DONE,
        ERR
    } state_t;

    state_t state, state_nx;

    logic [2:0]             sigma_r;
    logic [XW-1:0]          w_r;
    logic [YW-1:0]          h_r;
    logic [XW-1:0]          x_r;
    logic [YW-1:0]          y_r;
    logic [TW-1:0]          tcnt;
    logic [PIXEL_DEPTH-1:0] pix_r;
    logic                   err_r;

    logic size_ok;
    logic last_x;
    logic last_y;

    assign size_ok = (img_w != '0) && (img_w <= X_LIM) &&
                     (img_h != '0) && (img_h <= Y_LIM);
    assign last_x  = (x_r == w_r - X_ONE);
    assign last_y  = (y_r == h_r - Y_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = size_ok ? CONFIG : ERR;
                end
            end
            CONFIG:  state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT: begin
                // An engine error wins over a completion reported in the same cycle.
                if (conv_err) begin
                    state_nx = ERR;
                end else if (conv_done) begin
                    state_nx = WRITE;
                end else if (tcnt == T_LAST) begin
                    state_nx = ERR;
                end
            end
            WRITE:   state_nx = ADVANCE;
            ADVANCE: state_nx = (last_x && last_y) ? DONE : ISSUE;
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sigma_r <= '0;
            w_r     <= '0;
            h_r     <= '0;
            x_r     <= '0;
            y_r     <= '0;
            tcnt    <= '0;
            pix_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            if ((state == IDLE) && start && size_ok) begin
                sigma_r <= sigma_in;
                w_r     <= img_w;
                h_r     <= img_h;
                x_r     <= '0;
                y_r     <= '0;
                err_r   <= 1'b0;
            end
            // err stays up after ERR returns to IDLE, until a new pass is accepted.
            if (state_nx == ERR) begin
                err_r <= 1'b1;
            end
            if (state == ISSUE) begin
                tcnt <= '0;
            end
            if (state == WAIT) begin
                tcnt <= tcnt + T_ONE;
                if (conv_done) begin
                    pix_r <= blurred_pixel;
                end
            end
            if ((state == ADVANCE) && !(last_x && last_y)) begin
                if (!last_x) begin
                    x_r <= x_r + X_ONE;
                end else begin
                    x_r <= '0;
                    y_r <= y_r + Y_ONE;
                end
            end
        end
    end

    assign new_trans  = (state == CONFIG);
    assign start_conv = (state == ISSUE);
    assign out_wen    = (state == WRITE);
    assign done       = (state == DONE);
    assign busy       = (state != IDLE);
    assign err        = err_r;
    assign sigma      = sigma_r;
    assign conv_x     = x_r;
    assign conv_y     = y_r;
    assign out_x      = x_r;
    assign out_y      = y_r;
    assign out_wdat   = pix_r;

endmodule

// File: tb/tb_blur_sequencer.sv
// Directed bench for blur_sequencer with a small convolution-engine model and
// a negedge monitor that logs writes, pulses and their cycle stamps.
module tb_blur_sequencer;

    localparam int TO = 255;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] sigma_in;
    logic [4:0] img_w;
    logic [4:0] img_h;
    logic       new_trans;
    logic [2:0] sigma;
    logic       start_conv;
    logic [4:0] conv_x;
    logic [4:0] conv_y;
    logic       conv_done;
    logic [7:0] blurred_pixel;
    logic       conv_err;
    logic [4:0] out_x;
    logic [4:0] out_y;
    logic [7:0] out_wdat;
    logic       out_wen;
    logic       busy;
    logic       done;
    logic       err;

    blur_sequencer #(
        .X_MAX(16), .Y_MAX(16), .PIXEL_DEPTH(8), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sigma_in(sigma_in), .img_w(img_w), .img_h(img_h),
        .new_trans(new_trans), .sigma(sigma), .start_conv(start_conv),
        .conv_x(conv_x), .conv_y(conv_y), .conv_done(conv_done),
        .blurred_pixel(blurred_pixel), .conv_err(conv_err),
        .out_x(out_x), .out_y(out_y), .out_wdat(out_wdat), .out_wen(out_wen),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic logic [7:0] pix_of(input logic [4:0] x, input logic [4:0] y);
        return {x[3:0], y[3:0]} ^ 8'hA5;
    endfunction

    // Engine model: answers eng_lat cycles after seeing start_conv.
    int         eng_lat  = 3;
    bit         stall_en = 1'b0;
    logic [4:0] stall_x  = '0;
    logic [4:0] stall_y  = '0;
    bit         err_en   = 1'b0;
    logic [4:0] err_x    = '0;
    logic [4:0] err_y    = '0;
    bit         eng_dup  = 1'b0;

    logic       e_act;
    logic       e_dup;
    int         e_cnt;
    logic [4:0] e_x;
    logic [4:0] e_y;

    always @(posedge clk) begin
        if (rst) begin
            e_act         <= 1'b0;
            e_dup         <= 1'b0;
            e_cnt         <= 0;
            e_x           <= '0;
            e_y           <= '0;
            conv_done     <= 1'b0;
            conv_err      <= 1'b0;
            blurred_pixel <= '0;
        end else begin
            conv_done <= 1'b0;
            conv_err  <= 1'b0;
            if (start_conv) begin
                e_x   <= conv_x;
                e_y   <= conv_y;
                e_cnt <= eng_lat;
                e_act <= !(stall_en && conv_x == stall_x && conv_y == stall_y);
            end else if (e_act) begin
                if (e_cnt <= 1) begin
                    conv_done     <= 1'b1;
                    blurred_pixel <= pix_of(e_x, e_y);
                    conv_err      <= err_en && (e_x == err_x) && (e_y == err_y);
                    e_act         <= 1'b0;
                    e_dup         <= eng_dup;
                end else begin
                    e_cnt <= e_cnt - 1;
                end
            end else if (e_dup) begin
                conv_done     <= 1'b1;
                blurred_pixel <= 8'hFF;
                e_dup         <= 1'b0;
            end
        end
    end

    // Monitor
    logic [4:0] wx [0:1023];
    logic [4:0] wy [0:1023];
    logic [7:0] wd [0:1023];
    int         wc [0:1023];
    int         sc_cyc [0:1023];
    int wr_cnt = 0;
    int sc_cnt = 0;
    int nt_cnt = 0;
    int dn_cnt = 0;
    int dn_cyc = 0;
    int err_cyc = 0;
    int cyc = 0;
    logic err_q = 1'b0;

    always @(negedge clk) begin
        if (out_wen === 1'b1 && wr_cnt < 1024) begin
            wx[wr_cnt] = out_x;
            wy[wr_cnt] = out_y;
            wd[wr_cnt] = out_wdat;
            wc[wr_cnt] = cyc;
            wr_cnt++;
        end
        if (start_conv === 1'b1 && sc_cnt < 1024) begin
            sc_cyc[sc_cnt] = cyc;
            sc_cnt++;
        end
        if (new_trans === 1'b1) nt_cnt++;
        if (done === 1'b1) begin
            dn_cnt++;
            dn_cyc = cyc;
        end
        if (err === 1'b1 && err_q !== 1'b1) err_cyc = cyc;
        err_q = err;
        cyc++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [4:0] w, input logic [4:0] h, input logic [2:0] s);
        sigma_in = s;
        img_w    = w;
        img_h    = h;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_err(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (err === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pixel(input logic [4:0] x, input logic [4:0] y, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (start_conv === 1'b1 && conv_x == x && conv_y == y) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({new_trans, start_conv, out_wen, busy, done, err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {new_trans, start_conv, out_wen, busy, done, err});
        end
        checks++;
        if ({sigma, conv_x, conv_y, out_x, out_y, out_wdat} !== 31'b0) begin
            failures++;
            $display("FAIL reset_data: got %h, expected 0",
                     {sigma, conv_x, conv_y, out_x, out_y, out_wdat});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_image();
        int b_wr, b_sc, b_nt, b_dn, bad;
        bit ok;
        eng_lat = 3;
        b_wr = wr_cnt; b_sc = sc_cnt; b_nt = nt_cnt; b_dn = dn_cnt;
        pulse_start(5'd16, 5'd16, 3'd3);
        checks++;
        if ({new_trans, busy, start_conv} !== 3'b110) begin
            failures++;
            $display("FAIL config_cycle: got %b, expected 110", {new_trans, busy, start_conv});
        end
        tick();
        checks++;
        if ({new_trans, start_conv, conv_x, conv_y} !== {2'b01, 10'd0}) begin
            failures++;
            $display("FAIL first_issue: got nt=%b sc=%b x=%0d y=%0d, expected nt=0 sc=1 x=0 y=0",
                     new_trans, start_conv, conv_x, conv_y);
        end
        wait_idle(4000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL full_finish: got busy=%b, expected busy=0 within budget", busy);
        end
        checks++;
        if (nt_cnt - b_nt !== 1) begin
            failures++;
            $display("FAIL full_new_trans: got %0d, expected 1", nt_cnt - b_nt);
        end
        checks++;
        if (sc_cnt - b_sc !== 256) begin
            failures++;
            $display("FAIL full_start_conv: got %0d, expected 256", sc_cnt - b_sc);
        end
        checks++;
        if (wr_cnt - b_wr !== 256) begin
            failures++;
            $display("FAIL full_writes: got %0d, expected 256", wr_cnt - b_wr);
        end
        checks++;
        if (dn_cnt - b_dn !== 1) begin
            failures++;
            $display("FAIL full_done: got %0d, expected 1", dn_cnt - b_dn);
        end
        checks++;
        if ({err, sigma} !== 4'b0011) begin
            failures++;
            $display("FAIL full_status: got err=%b sigma=%0d, expected err=0 sigma=3", err, sigma);
        end
        bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (wx[b_wr+i] !== 5'(i % 16) || wy[b_wr+i] !== 5'(i / 16) ||
                wd[b_wr+i] !== pix_of(5'(i % 16), 5'(i / 16))) begin
                bad = i;
                break;
            end
        end
        checks++;
        if (bad != -1) begin
            failures++;
            $display("FAIL raster_order: write %0d got (%0d,%0d)=%h, expected (%0d,%0d)=%h",
                     bad, wx[b_wr+bad], wy[b_wr+bad], wd[b_wr+bad], bad % 16, bad / 16,
                     pix_of(5'(bad % 16), 5'(bad / 16)));
        end
        checks++;
        if (sc_cyc[b_sc+1] - sc_cyc[b_sc] !== 7 || sc_cyc[b_sc+16] - sc_cyc[b_sc+15] !== 7) begin
            failures++;
            $display("FAIL pixel_period: got %0d and %0d, expected 7 and 7",
                     sc_cyc[b_sc+1] - sc_cyc[b_sc], sc_cyc[b_sc+16] - sc_cyc[b_sc+15]);
        end
        checks++;
        if (dn_cyc - wc[b_wr+255] !== 2) begin
            failures++;
            $display("FAIL done_after_last_write: got %0d, expected 2", dn_cyc - wc[b_wr+255]);
        end
    endtask

    task automatic test_bad_size();
        int b_wr, b_nt;
        b_wr = wr_cnt; b_nt = nt_cnt;
        pulse_start(5'd0, 5'd4, 3'd1);
        checks++;
        if ({err, busy} !== 2'b11) begin
            failures++;
            $display("FAIL bad_w0: got err=%b busy=%b, expected err=1 busy=1", err, busy);
        end
        tick();
        checks++;
        if ({err, busy} !== 2'b10) begin
            failures++;
            $display("FAIL err_hold: got err=%b busy=%b, expected err=1 busy=0", err, busy);
        end
        pulse_start(5'd17, 5'd4, 3'd1);
        checks++;
        if ({err, busy} !== 2'b11) begin
            failures++;
            $display("FAIL bad_w17: got err=%b busy=%b, expected err=1 busy=1", err, busy);
        end
        tick();
        pulse_start(5'd4, 5'd0, 3'd1);
        checks++;
        if ({err, busy} !== 2'b11) begin
            failures++;
            $display("FAIL bad_h0: got err=%b busy=%b, expected err=1 busy=1", err, busy);
        end
        tick();
        tick();
        checks++;
        if (nt_cnt - b_nt !== 0 || wr_cnt - b_wr !== 0) begin
            failures++;
            $display("FAIL bad_no_activity: got nt=%0d wr=%0d, expected 0 and 0",
                     nt_cnt - b_nt, wr_cnt - b_wr);
        end
        checks++;
        if (sigma !== 3'd3) begin
            failures++;
            $display("FAIL bad_sigma_kept: got %0d, expected 3", sigma);
        end
    endtask

    task automatic test_timeout();
        int b_wr, b_dn;
        bit ok;
        stall_en = 1'b1; stall_x = 5'd2; stall_y = 5'd0;
        b_wr = wr_cnt; b_dn = dn_cnt;
        pulse_start(5'd4, 5'd4, 3'd2);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear_on_start: got %b, expected 0", err);
        end
        wait_err(TO + 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_err: got err=%b, expected err=1 within budget", err);
        end
        checks++;
        if (err_cyc - sc_cyc[sc_cnt-1] !== TO + 1) begin
            failures++;
            $display("FAIL timeout_cycles: got %0d, expected %0d", err_cyc - sc_cyc[sc_cnt-1], TO + 1);
        end
        checks++;
        if (wr_cnt - b_wr !== 2 || dn_cnt - b_dn !== 0) begin
            failures++;
            $display("FAIL timeout_writes: got wr=%0d done=%0d, expected 2 and 0",
                     wr_cnt - b_wr, dn_cnt - b_dn);
        end
        tick();
        checks++;
        if ({err, busy} !== 2'b10) begin
            failures++;
            $display("FAIL timeout_idle: got err=%b busy=%b, expected err=1 busy=0", err, busy);
        end
        stall_en = 1'b0;
    endtask

    task automatic test_err_priority();
        int b_wr, b_dn;
        bit ok;
        err_en = 1'b1; err_x = 5'd0; err_y = 5'd1;
        b_wr = wr_cnt; b_dn = dn_cnt;
        pulse_start(5'd4, 5'd4, 3'd4);
        wait_err(200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL conv_err_seen: got err=%b, expected err=1 within budget", err);
        end
        wait_idle(20, ok);
        checks++;
        if (wr_cnt - b_wr !== 4 || dn_cnt - b_dn !== 0) begin
            failures++;
            $display("FAIL conv_err_writes: got wr=%0d done=%0d, expected 4 and 0",
                     wr_cnt - b_wr, dn_cnt - b_dn);
        end
        checks++;
        if (wx[wr_cnt-1] !== 5'd3 || wy[wr_cnt-1] !== 5'd0) begin
            failures++;
            $display("FAIL conv_err_last_write: got (%0d,%0d), expected (3,0)",
                     wx[wr_cnt-1], wy[wr_cnt-1]);
        end
        err_en = 1'b0;
    endtask

    task automatic test_abort();
        int b_wr, b_dn, b_nt;
        bit ok;
        eng_lat = 2;
        b_wr = wr_cnt; b_dn = dn_cnt; b_nt = nt_cnt;
        pulse_start(5'd4, 5'd4, 3'd5);
        wait_pixel(5'd2, 5'd0, 100, ok);
        sigma_in = 3'd7; img_w = 5'd2; img_h = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, sigma} !== 4'b1101) begin
            failures++;
            $display("FAIL start_while_busy: got busy=%b sigma=%0d, expected busy=1 sigma=5", busy, sigma);
        end
        wait_pixel(5'd1, 5'd1, 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL abort_reach_px5: got no issue of (1,1), expected one within budget");
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b done=%b err=%b, expected 000", busy, done, err);
        end
        checks++;
        if (wr_cnt - b_wr !== 5) begin
            failures++;
            $display("FAIL abort_writes: got %0d, expected 5", wr_cnt - b_wr);
        end
        repeat (20) tick();
        checks++;
        if (wr_cnt - b_wr !== 5 || dn_cnt - b_dn !== 0 || nt_cnt - b_nt !== 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet: got wr=%0d done=%0d nt=%0d err=%b, expected 5 0 1 0",
                     wr_cnt - b_wr, dn_cnt - b_dn, nt_cnt - b_nt, err);
        end
    endtask

    task automatic test_rst_mid_pass();
        int b_wr, b_dn;
        bit ok;
        eng_lat = 1;
        b_wr = wr_cnt;
        pulse_start(5'd4, 5'd4, 3'd6);
        for (int i = 0; i < 200 && (wr_cnt - b_wr) < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, err, out_wen, sigma} !== 7'b0) begin
            failures++;
            $display("FAIL rst_mid_state: got busy=%b done=%b err=%b wen=%b sigma=%0d, expected all 0",
                     busy, done, err, out_wen, sigma);
        end
        b_wr = wr_cnt; b_dn = dn_cnt;
        repeat (20) tick();
        checks++;
        if (wr_cnt - b_wr !== 0 || dn_cnt - b_dn !== 0) begin
            failures++;
            $display("FAIL rst_mid_quiet: got wr=%0d done=%0d, expected 0 and 0",
                     wr_cnt - b_wr, dn_cnt - b_dn);
        end
        pulse_start(5'd1, 5'd1, 3'd2);
        wait_idle(100, ok);
        checks++;
        if (wr_cnt - b_wr !== 1 || dn_cnt - b_dn !== 1) begin
            failures++;
            $display("FAIL one_px_counts: got wr=%0d done=%0d, expected 1 and 1",
                     wr_cnt - b_wr, dn_cnt - b_dn);
        end
        checks++;
        if (wx[b_wr] !== 5'd0 || wy[b_wr] !== 5'd0 || wd[b_wr] !== pix_of(5'd0, 5'd0) ||
            dn_cyc <= wc[b_wr]) begin
            failures++;
            $display("FAIL one_px_write: got (%0d,%0d)=%h wc=%0d dc=%0d, expected (0,0)=%h before done",
                     wx[b_wr], wy[b_wr], wd[b_wr], wc[b_wr], dn_cyc, pix_of(5'd0, 5'd0));
        end
    endtask

    task automatic test_spurious_done();
        int b_wr, b_sc, b_dn, bad;
        bit ok;
        eng_lat = 1; eng_dup = 1'b1;
        b_wr = wr_cnt; b_sc = sc_cnt; b_dn = dn_cnt;
        pulse_start(5'd2, 5'd2, 3'd1);
        wait_idle(200, ok);
        checks++;
        if (wr_cnt - b_wr !== 4 || dn_cnt - b_dn !== 1) begin
            failures++;
            $display("FAIL spurious_counts: got wr=%0d done=%0d, expected 4 and 1",
                     wr_cnt - b_wr, dn_cnt - b_dn);
        end
        bad = -1;
        for (int i = 0; i < 4; i++) begin
            if (wd[b_wr+i] !== pix_of(5'(i % 2), 5'(i / 2))) begin
                bad = i;
                break;
            end
        end
        checks++;
        if (bad != -1) begin
            failures++;
            $display("FAIL spurious_data: write %0d got %h, expected %h",
                     bad, wd[b_wr+bad], pix_of(5'(bad % 2), 5'(bad / 2)));
        end
        checks++;
        if (sc_cyc[b_sc+1] - sc_cyc[b_sc] !== 5) begin
            failures++;
            $display("FAIL spurious_period: got %0d, expected 5", sc_cyc[b_sc+1] - sc_cyc[b_sc]);
        end
        eng_dup = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        sigma_in = '0; img_w = '0; img_h = '0;
        test_reset();
        test_full_image();
        test_bad_size();
        test_timeout();
        test_err_priority();
        test_abort();
        test_rst_mid_pass();
        test_spurious_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/blur_sequencer.md
BLUR_SEQUENCER -- requirements
Module: blur_sequencer

Interface
REQ-001 Parameter X_MAX, default 16, maximum image width in pixels.
REQ-002 Parameter Y_MAX, default 16, maximum image height in pixels.
REQ-003 Parameter PIXEL_DEPTH, default 8, pixel width in bits.
REQ-004 Parameter TIMEOUT, default 255, maximum WAIT cycles per pixel before error.
REQ-005 Port clk  in  1  sole clock; all logic on rising edge.
REQ-006 Port rst  in  1  reset, synchronous, active-high.
REQ-007 Port start  in  1  single-cycle pulse that begins one full-image blur pass.
REQ-008 Port abort  in  1  level input; terminates the pass from any non-IDLE state.
REQ-009 Port sigma_in  in  3  blur strength, latched on accepted start.
REQ-010 Port img_w / img_h  in  $clog2(X_MAX)+1 / $clog2(Y_MAX)+1  image size, latched on accepted start.
REQ-011 Port new_trans  out  1  one-cycle pulse to the convolution engine to reload its kernel.
REQ-012 Port sigma  out  3  latched sigma, held stable for the whole pass.
REQ-013 Port start_conv  out  1  one-cycle pulse requesting one output pixel at (conv_x, conv_y).
REQ-014 Port conv_x / conv_y  out  same widths as img_w / img_h  centre coordinate of the current pixel.
REQ-015 Port conv_done  in  1  engine completion pulse; qualifies blurred_pixel.
REQ-016 Port blurred_pixel  in  PIXEL_DEPTH  engine result.
REQ-017 Port conv_err  in  1  engine error flag.
REQ-018 Port out_x / out_y / out_wdat / out_wen  out  addr widths / PIXEL_DEPTH / 1  output image SRAM write port.
REQ-019 Port busy / done / err  out  1 / 1 / 1  status outputs.

Function
REQ-020 States SHALL be IDLE, CONFIG, ISSUE, WAIT, WRITE, ADVANCE, DONE, ERR.
REQ-021 IDLE: start with 1<=img_w<=X_MAX and 1<=img_h<=Y_MAX latches inputs, clears err and the coordinates, and moves to CONFIG; start with an out-of-range size moves to ERR.
REQ-022 CONFIG: assert new_trans for exactly one cycle, then move to ISSUE on the next cycle.
REQ-023 ISSUE: assert start_conv for one cycle with conv_x/conv_y valid, clear the timeout counter, then move to WAIT.
REQ-024 WAIT: on conv_done, capture blurred_pixel and move to WRITE.
REQ-025 WAIT: conv_err=1 moves to ERR and SHALL take priority over a conv_done in the same cycle.
REQ-026 WAIT: the timeout counter SHALL increment each cycle; reaching TIMEOUT without conv_done moves to ERR.
REQ-027 WRITE: assert out_wen for exactly one cycle with out_x=conv_x, out_y=conv_y, out_wdat=captured pixel, then move to ADVANCE.
REQ-028 ADVANCE: raster order. If x<img_w-1, x+1. Otherwise x=0 and y+1. If x=img_w-1 and y=img_h-1, move to DONE instead of ISSUE.
REQ-029 DONE: assert done for exactly one cycle, then return to IDLE.
REQ-030 ERR: assert err and hold it until the next accepted start or rst; move to IDLE after one cycle.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 abort=1 in any non-IDLE state SHALL return to IDLE next cycle, with no done, no err and no further out_wen.
REQ-034 Pixel throughput SHALL be ISSUE(1) + WAIT(>=1) + WRITE(1) + ADVANCE(1) cycles.
REQ-035 A 1x1 image SHALL produce exactly one write followed by done.
REQ-036 conv_done outside WAIT SHALL be ignored.

Reset
REQ-037 On rst=1 at a clock edge: state=IDLE.
REQ-038 On rst=1 at a clock edge, all outputs SHALL be 0, including new_trans, start_conv, out_wen, busy, done, err, sigma and the coordinates.
REQ-039 rst mid-pass SHALL abandon the pass with no further writes and no done.

Verification
REQ-040 16x16 image, sigma=3, engine model with 3-cycle latency -> 1 new_trans, 256 start_conv, 256 writes in raster order (0,0)..(15,15), done pulses once, err=0.
REQ-041 img_w=0 or img_w=17 on start -> ERR within 1 cycle, err=1, no new_trans, no out_wen.
REQ-042 Engine stalls at pixel (2,0) -> err=1 after exactly TIMEOUT WAIT cycles; only 2 writes recorded.
REQ-043 conv_err and conv_done asserted together at pixel (0,1) -> ERR, no write for (0,1).
REQ-044 abort at pixel 5 of 4x4 -> IDLE next cycle, busy=0, done=0, err=0; a second start while busy is ignored.
REQ-045 rst mid-pass, then a 1x1 start -> exactly 1 write at (0,0), then done.
